// File: rtl/phy_rx_pkg.sv
// Shared RX/TX PHY constants: comma symbol, lock depth and the aligner state encoding.
package phy_rx_pkg;

    localparam logic [7:0] COMMA_BYTE = 8'hBC;
    localparam int DEFAULT_COMMA_LOCK_CNT = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

    // Byte starting k bits into the 16-bit window; k=0 is the older byte.
    function automatic logic [7:0] slice_at(input logic [15:0] w, input logic [2:0] k);
        logic [15:0] sh;
        sh = w >> (4'd8 - {1'b0, k});
        return sh[7:0];
    endfunction

endpackage

// File: rtl/phy_rx_byte_sync_comma_finder.sv
// Combinational comma detector: flags every bit offset of a 16-bit window holding the comma.
module phy_rx_comma_finder #(
    parameter logic [7:0] COMMA_BYTE = phy_rx_pkg::COMMA_BYTE
) (
    input  logic [15:0] w,
    output logic [7:0]  match,
    output logic        any_match,
    output logic [2:0]  lowest_off
);
    for (genvar k = 0; k < 8; k++) begin : g_off
        assign match[k] = (w[15-k -: 8] == COMMA_BYTE);
    end

    assign any_match = |match;

    always_comb begin
        lowest_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (match[k]) lowest_off = 3'(k);
        end
    end

endmodule

// File: rtl/phy_rx_byte_sync.sv
// RX comma aligner and sticky lock FSM (clk_4f domain), feeding aligned bytes to demuxL1.
// Define RX_BYTE_SYNC_STATS_EN to add saturating comma/data counters while locked.
module phy_rx_byte_sync #(
    parameter int         COMMA_LOCK_CNT = phy_rx_pkg::DEFAULT_COMMA_LOCK_CNT,
    parameter logic [7:0] COMMA_BYTE     = phy_rx_pkg::COMMA_BYTE
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  raw_byte,
    input  logic        raw_valid,
    output logic [7:0]  data_serial_paralelo,
    output logic        valid_serial_paralelo,
    output logic        active,
    output logic [2:0]  align_offset
`ifdef RX_BYTE_SYNC_STATS_EN
    ,
    output logic [15:0] comma_count,
    output logic [15:0] data_count
`endif
);
    import phy_rx_pkg::*;

    localparam logic [3:0] LOCK_CNT = 4'(COMMA_LOCK_CNT);

    rx_state_e   state;
    logic [7:0]  prev_byte;
    logic [15:0] w;
    logic [2:0]  cand_off, cand_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  match;
    logic        any_match;
    logic [2:0]  lowest_off;
    logic [7:0]  locked_slice;

    assign w            = {prev_byte, raw_byte};
    assign locked_slice = slice_at(w, align_offset);

    phy_rx_comma_finder #(.COMMA_BYTE(COMMA_BYTE)) u_finder (
        .w          (w),
        .match      (match),
        .any_match  (any_match),
        .lowest_off (lowest_off)
    );

    // A running candidate wins over lower offsets that happen to match too.
    always_comb begin
        cnt_nxt  = 4'd0;
        cand_nxt = cand_off;
        if (cnt != 4'd0 && match[cand_off]) begin
            cnt_nxt = (cnt == LOCK_CNT) ? cnt : cnt + 4'd1;
        end else if (any_match) begin
            cand_nxt = lowest_off;
            cnt_nxt  = 4'd1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state                 <= SEARCH;
            prev_byte             <= 8'd0;
            cand_off              <= 3'd0;
            cnt                   <= 4'd0;
            data_serial_paralelo  <= 8'd0;
            valid_serial_paralelo <= 1'b0;
            active                <= 1'b0;
            align_offset          <= 3'd0;
`ifdef RX_BYTE_SYNC_STATS_EN
            comma_count           <= 16'd0;
            data_count            <= 16'd0;
`endif
        end else begin
            valid_serial_paralelo <= 1'b0;
            if (raw_valid) begin
                prev_byte <= raw_byte;
                if (state == SEARCH) begin
                    cnt      <= cnt_nxt;
                    cand_off <= cand_nxt;
                    if (cnt_nxt == LOCK_CNT) begin
                        state        <= LOCKED;
                        align_offset <= cand_nxt;
                        active       <= 1'b1;
                    end
                end else begin
                    // Locked is sticky: garbage is forwarded, never drops lock.
                    data_serial_paralelo  <= locked_slice;
                    valid_serial_paralelo <= (locked_slice != COMMA_BYTE);
`ifdef RX_BYTE_SYNC_STATS_EN
                    if (locked_slice == COMMA_BYTE) begin
                        if (comma_count != 16'hFFFF) comma_count <= comma_count + 16'd1;
                    end else begin
                        if (data_count != 16'hFFFF) data_count <= data_count + 16'd1;
                    end
`endif
                end
            end
        end
    end

endmodule
